// File: rtl/lcd_pkg.sv
// lcd_pkg: shared clear-FSM encoding and default fill character for the text buffer.
package lcd_pkg;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;
  localparam logic [7:0] FILL_DEF = 8'h20;
endpackage

// File: rtl/text_buffer_if.sv
// text_buffer_if: write, pointer, read and clear signals of the text buffer.
interface text_buffer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11
);
  logic              wr_en;
  logic              wr_auto;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              ptr_load;
  logic [ADDR_W-1:0] ptr_val;
  logic              wr_drop;
  logic [ADDR_W-1:0] wr_ptr;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              clr_start;
  logic              busy;
  logic              clr_done;
  modport master (
    output wr_en, wr_auto, wr_addr, wr_data, ptr_load, ptr_val, rd_req, rd_addr, clr_start,
    input  wr_drop, wr_ptr, rd_valid, rd_data, busy, clr_done
  );
  modport slave (
    input  wr_en, wr_auto, wr_addr, wr_data, ptr_load, ptr_val, rd_req, rd_addr, clr_start,
    output wr_drop, wr_ptr, rd_valid, rd_data, busy, clr_done
  );
endinterface

// File: rtl/text_buffer_sdp_ram.sv
// sdp_ram: read-first simple dual-port RAM, contents preset to INIT_VAL at configuration.
module sdp_ram #(
  parameter int                 DATA_W   = 8,
  parameter int                 ADDR_W   = 11,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] mem [2**ADDR_W] = '{default: INIT_VAL};
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end
endmodule

// File: rtl/text_buffer.sv
// text_buffer: character buffer with auto-increment write pointer, registered reads and a full-buffer clear engine.
module text_buffer
  import lcd_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 11,
  parameter logic [DATA_W-1:0] FILL_VAL = DATA_W'(FILL_DEF)
) (
  input logic          clk,
  input logic          rst,
  text_buffer_if.slave bus
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(2**ADDR_W - 1);
  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, wr_ptr_q, wr_ptr_d;
  logic              wr_drop_q, wr_drop_d, rd_valid_q, rd_valid_d, rd_seen_q, rd_seen_d;
  logic              busy, wr_ok, ram_we;
  logic [ADDR_W-1:0] ptr_base, ram_waddr;
  logic [DATA_W-1:0] ram_wdata, ram_q;
  always_comb begin
    busy       = state_q == ST_CLEAR;
    wr_ok      = bus.wr_en && !busy;
    ptr_base   = bus.ptr_load ? bus.ptr_val : wr_ptr_q;
    // memory is never touched while reset is held, so an aborted clear stays partial
    ram_we     = !rst && (busy || wr_ok);
    ram_waddr  = busy ? cnt_q : (bus.wr_auto ? ptr_base : bus.wr_addr);
    ram_wdata  = busy ? FILL_VAL : bus.wr_data;
    wr_ptr_d   = ptr_base + ADDR_W'(wr_ok && bus.wr_auto);
    state_d    = busy ? (cnt_q == LAST ? ST_IDLE : ST_CLEAR) : (bus.clr_start ? ST_CLEAR : ST_IDLE);
    cnt_d      = busy ? cnt_q + ADDR_W'(1) : '0;
    wr_drop_d  = bus.wr_en && busy;
    rd_valid_d = bus.rd_req;
    rd_seen_d  = rd_seen_q || bus.rd_req;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      wr_drop_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_seen_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_drop_q  <= wr_drop_d;
      rd_valid_q <= rd_valid_d;
      rd_seen_q  <= rd_seen_d;
    end
  end
  sdp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .INIT_VAL(FILL_VAL)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (bus.rd_req),
    .raddr (bus.rd_addr),
    .q     (ram_q)
  );
  // RAM output carries no reset, so read data reads as zero until the first read after reset
  assign bus.rd_data  = rd_seen_q ? ram_q : '0;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = busy;
  assign bus.clr_done = busy && cnt_q == LAST;
  assign bus.wr_drop  = wr_drop_q;
  assign bus.wr_ptr   = wr_ptr_q;
endmodule

// File: tb/tb_text_buffer.sv
// tb_text_buffer: randomized and directed stimulus against an array reference model with a read scoreboard.
module tb_text_buffer;
  localparam int         DW    = 8;
  localparam int         AW    = 11;
  localparam int         DEPTH = 2**AW;
  localparam logic [7:0] FILL  = 8'h20;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  text_buffer_if #(.DATA_W(DW), .ADDR_W(AW)) bus();
  text_buffer #(.DATA_W(DW), .ADDR_W(AW), .FILL_VAL(FILL)) dut (.clk(clk), .rst(rst), .bus(bus));
  int         total = 0, passed = 0;
  int         busy_n = 0, done_n = 0;
  logic [7:0] model [DEPTH];
  int         ptr = 0, clr_pos = -1;
  logic       drop_exp = 1'b0, prev_rd = 1'b0;
  logic [7:0] last_rd = '0;
  logic [7:0] exp_q [$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  always @(negedge clk) if (!rst) begin
    logic [7:0] e;
    if (bus.rd_valid) begin
      if (exp_q.size() == 0) chk("rd_valid_spurious", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("rd_data", {24'd0, bus.rd_data}, {24'd0, e});
        last_rd = e;
      end
    end else chk("rd_data_hold", {24'd0, bus.rd_data}, {24'd0, last_rd});
    if (bus.busy) busy_n++;
    if (bus.clr_done) done_n++;
  end
  task automatic idle();
    bus.wr_en = 0; bus.wr_auto = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.ptr_load = 0; bus.ptr_val = '0; bus.rd_req = 0; bus.rd_addr = '0; bus.clr_start = 0;
  endtask
  task automatic cycle();
    int  p;
    bit  bsy;
    @(negedge clk);
    chk("busy", 32'(bus.busy), 32'(clr_pos >= 0));
    chk("clr_done", 32'(bus.clr_done), 32'(clr_pos == DEPTH-1));
    chk("wr_ptr", 32'(bus.wr_ptr), 32'(ptr));
    chk("wr_drop", 32'(bus.wr_drop), 32'(drop_exp));
    chk("rd_valid", 32'(bus.rd_valid), 32'(prev_rd));
    @(posedge clk);
    prev_rd = bus.rd_req;
    if (bus.rd_req) exp_q.push_back(model[bus.rd_addr]);
    bsy = clr_pos >= 0;
    p = bus.ptr_load ? int'(bus.ptr_val) : ptr;
    drop_exp = bus.wr_en && bsy;
    if (bsy) begin
      model[clr_pos] = FILL;
      clr_pos = (clr_pos == DEPTH-1) ? -1 : clr_pos + 1;
    end else begin
      if (bus.wr_en) begin
        model[bus.wr_auto ? p : int'(bus.wr_addr)] = bus.wr_data;
        if (bus.wr_auto) p = (p + 1) % DEPTH;
      end
      if (bus.clr_start) clr_pos = 0;
    end
    ptr = p;
    #1;
  endtask
  task automatic do_reset();
    rst = 1; idle();
    clr_pos = -1; ptr = 0; drop_exp = 0; prev_rd = 0; last_rd = '0; exp_q.delete();
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_wr_ptr", 32'(bus.wr_ptr), 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
    chk("rst_wr_drop", 32'(bus.wr_drop), 32'd0);
    chk("rst_clr_done", 32'(bus.clr_done), 32'd0);
    @(posedge clk); #1;
    rst = 0;
  endtask
  task automatic wr(input int a, input logic [7:0] d);
    idle(); bus.wr_en = 1; bus.wr_addr = AW'(a); bus.wr_data = d; cycle();
  endtask
  task automatic rd(input int a);
    idle(); bus.rd_req = 1; bus.rd_addr = AW'(a); cycle();
  endtask
  task automatic auto_wr(input logic [7:0] d);
    idle(); bus.wr_en = 1; bus.wr_auto = 1; bus.wr_data = d; cycle();
  endtask
  initial begin
    foreach (model[i]) model[i] = FILL;
    idle();
    #2;
    do_reset();
    // addressed write then read back
    wr(5, 8'h41); rd(5); idle(); cycle();
    // pointer wrap across the top of the buffer
    idle(); bus.ptr_load = 1; bus.ptr_val = AW'(DEPTH-2); cycle();
    auto_wr(8'h41); auto_wr(8'h42); auto_wr(8'h43);
    chk("ptr_wrap", 32'(bus.wr_ptr), 32'd1);
    rd(DEPTH-2); rd(DEPTH-1); rd(0);
    // ptr_load wins over the current pointer for a same-cycle auto write
    idle(); bus.ptr_load = 1; bus.ptr_val = AW'(10); bus.wr_en = 1; bus.wr_auto = 1; bus.wr_data = 8'h5a; cycle();
    chk("ptr_load_auto", 32'(bus.wr_ptr), 32'd11);
    rd(10);
    // read-first collision
    idle(); bus.wr_en = 1; bus.wr_addr = AW'(7); bus.wr_data = 8'h55; bus.rd_req = 1; bus.rd_addr = AW'(7); cycle();
    rd(7);
    // random traffic concentrated on a few addresses to provoke collisions
    for (int i = 0; i < 400; i++) begin
      idle();
      bus.wr_en    = 1'($urandom);
      bus.wr_auto  = 1'($urandom);
      bus.wr_addr  = AW'($urandom_range(0, 15));
      bus.wr_data  = 8'($urandom);
      bus.ptr_load = ($urandom_range(0, 7) == 0);
      bus.ptr_val  = ($urandom_range(0, 3) == 0) ? AW'(DEPTH-1) : AW'($urandom_range(0, 15));
      bus.rd_req   = 1'($urandom);
      bus.rd_addr  = AW'($urandom_range(0, 15));
      cycle();
    end
    // full clear with a coinciding write, then blocked writes while busy
    wr(300, 8'h77);
    busy_n = 0; done_n = 0;
    idle(); bus.clr_start = 1; bus.wr_en = 1; bus.wr_addr = AW'(301); bus.wr_data = 8'h11; cycle();
    wr(300, 8'h99);
    auto_wr(8'h98);
    idle(); bus.ptr_load = 1; bus.ptr_val = AW'(5); bus.wr_en = 1; bus.wr_auto = 1; bus.wr_data = 8'h97; cycle();
    idle(); bus.clr_start = 1; cycle();
    for (int i = 0; i < DEPTH + 10 && clr_pos >= 0; i++) begin
      idle(); bus.rd_req = 1'($urandom); bus.rd_addr = AW'($urandom_range(0, DEPTH-1)); cycle();
    end
    idle(); cycle();
    chk("busy_cycles", 32'(busy_n), 32'(DEPTH));
    chk("clr_done_count", 32'(done_n), 32'd1);
    chk("ptr_after_clear", 32'(bus.wr_ptr), 32'd5);
    for (int a = 0; a < DEPTH; a++) rd(a);
    // reset part-way through a clear
    wr(200, 8'h66); wr(50, 8'h33); wr(150, 8'h44);
    idle(); bus.clr_start = 1; cycle();
    for (int i = 0; i < 200 && clr_pos != 100; i++) begin idle(); cycle(); end
    do_reset();
    for (int a = 0; a < 102; a++) rd(a);
    rd(150); rd(200);
    idle(); cycle(); cycle();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
